// File: rtl/time_pkg.sv
// Shared types, field limits and BCD helpers for the time keeper.
package time_pkg;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    localparam bcd_t SEC_MAX = 8'h59;
    localparam bcd_t MIN_MAX = 8'h59;

    // Both digits decimal and the pair not above the field limit.
    function automatic logic bcd_valid(input bcd_t v, input bcd_t max);
        logic [7:0] raw_v;
        logic [7:0] raw_max;
        raw_v   = v;
        raw_max = max;
        return (v.tens <= 4'd9) && (v.units <= 4'd9) && (raw_v <= raw_max);
    endfunction

    // Binary 0..99 to packed BCD; used to derive the hour limit.
    function automatic bcd_t to_bcd(input int unsigned n);
        bcd_t r;
        r.tens  = 4'(n / 10);
        r.units = 4'(n % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX_BCD with preset and a carry-out on wrap.
module bcd_mod_counter
    import time_pkg::*;
#(
    parameter bcd_t MAX_BCD = SEC_MAX
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic wrap
);

    bcd_t q_d;

    // Carry to the next field in the same cycle this one rolls over.
    assign wrap = inc && (q == MAX_BCD);

    // Next value: preset wins, otherwise decimal increment with wrap to 00.
    always_comb begin
        q_d = q;
        if (ld) begin
            q_d = ld_val;
        end else if (inc) begin
            if (q == MAX_BCD) begin
                q_d = '0;
            end else if (q.units == 4'd9) begin
                q_d.tens  = q.tens + 4'd1;
                q_d.units = 4'd0;
            end else begin
                q_d.units = q.units + 4'd1;
            end
        end
    end

    // Field register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) q <= '0;
        else     q <= q_d;
    end

endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss clock advanced by rising edges of a 1 Hz level, with
// validated preset, sticky preset error and a day rollover strobe.
module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       day_pulse,
    output logic       load_err
);

    localparam bcd_t HOUR_MAX_BCD = to_bcd(HOUR_MAX);

    logic tick_q;
    logic sec_evt;
    logic preset_ok;
    logic ld;
    logic inc_ss;
    logic wrap_ss;
    logic wrap_mm;
    logic wrap_hh;
    logic day_pulse_d;
    logic load_err_d;
    bcd_t hh_q;
    bcd_t mm_q;
    bcd_t ss_q;

    assign sec_evt   = tick_in & ~tick_q;
    assign preset_ok = bcd_valid(load_ss, SEC_MAX) && bcd_valid(load_mm, MIN_MAX)
                       && bcd_valid(load_hh, HOUR_MAX_BCD);
    assign ld        = load & preset_ok;
    // Load holds the count even when the preset is rejected; that tick is lost.
    assign inc_ss    = sec_evt & run & ~load;

    // Edge detector history; keeps tracking during load and while stopped.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) tick_q <= 1'b0;
        else     tick_q <= tick_in;
    end

    bcd_mod_counter #(
        .MAX_BCD (SEC_MAX)
    ) u_ss (
        .clk    (clk),
        .clr    (clr),
        .inc    (inc_ss),
        .ld     (ld),
        .ld_val (load_ss),
        .q      (ss_q),
        .wrap   (wrap_ss)
    );

    bcd_mod_counter #(
        .MAX_BCD (MIN_MAX)
    ) u_mm (
        .clk    (clk),
        .clr    (clr),
        .inc    (wrap_ss),
        .ld     (ld),
        .ld_val (load_mm),
        .q      (mm_q),
        .wrap   (wrap_mm)
    );

    bcd_mod_counter #(
        .MAX_BCD (HOUR_MAX_BCD)
    ) u_hh (
        .clk    (clk),
        .clr    (clr),
        .inc    (wrap_mm),
        .ld     (ld),
        .ld_val (load_hh),
        .q      (hh_q),
        .wrap   (wrap_hh)
    );

    assign hh = hh_q;
    assign mm = mm_q;
    assign ss = ss_q;

    // Status next-state: strobe on full rollover, error tracks the latest load.
    always_comb begin
        day_pulse_d = wrap_hh;
        load_err_d  = load_err;
        if (load) load_err_d = ~preset_ok;
    end

    // Status registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            day_pulse <= day_pulse_d;
            load_err  <= load_err_d;
        end
    end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter HOUR_MAX, default 23, meaning the last hour value before the hour count wraps to 00 (23 gives 24-h mode).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port tick_in, input, 1, level-type 1 Hz waveform, synchronous to clk; only its rising edges count.
REQ-005 SHALL have port run, input, 1, count enable; 0 freezes the time.
REQ-006 SHALL have port load, input, 1, synchronous preset strobe, level-sensitive.
REQ-007 SHALL have ports load_hh, load_mm, load_ss, input, 8 each, packed BCD preset values {tens, units}.
REQ-008 SHALL have ports hh, mm, ss, output, 8 each, packed BCD current time, registered.
REQ-009 SHALL have port day_pulse, output, 1, one-cycle strobe on the HOUR_MAX:59:59 -> 00:00:00 rollover.
REQ-010 SHALL have port load_err, output, 1, sticky flag for a rejected preset.

Function
REQ-011 SHALL register tick_in into tick_q every cycle, including while load=1 or run=0; sec_evt = tick_in & ~tick_q.
REQ-012 SHALL advance ss by one on the clk edge where sec_evt=1, run=1 and load=0: outputs change exactly 1 cycle after tick_in is first sampled high.
REQ-013 SHALL count ss 00..59, then wrap to 00 and carry to mm in the same cycle.
REQ-014 SHALL count mm 00..59, then wrap to 00 and carry to hh in the same cycle when the ss carry is present.
REQ-015 SHALL count hh 00..HOUR_MAX, then wrap to 00 in the same cycle when the mm carry is present.
REQ-016 SHALL assert day_pulse for exactly the cycle in which hh:mm:ss shows 00:00:00 after a wrap from HOUR_MAX:59:59; it SHALL be 0 otherwise.
REQ-017 SHALL keep every BCD units digit in 0..9: units 9 -> 0 increments the tens digit; no binary value 0x0A..0x0F ever appears.
REQ-018 SHALL, while load=1, copy load_hh/mm/ss into hh/mm/ss on every clk edge when the preset is valid.
REQ-019 SHALL define a valid preset as all six digits <= 9, ss <= 0x59, mm <= 0x59 and hh <= BCD(HOUR_MAX).
REQ-020 SHALL, on an invalid preset, leave hh/mm/ss unchanged and set load_err to 1.
REQ-021 SHALL keep load_err at 1 until the next valid load or clr clears it.
REQ-022 SHALL give load priority over a coincident sec_evt; that tick is discarded and not deferred.
REQ-023 SHALL discard sec_evt when run=0; leaving run=0 does not replay missed ticks.
REQ-024 SHALL count a tick_in that is already high when load falls only if a rising edge occurs afterwards, since tick_q keeps tracking during load (REQ-011).
REQ-025 SHALL never assert day_pulse as a result of a load.

Reset
REQ-026 SHALL, while clr=1, force hh=ss=mm=0x00, day_pulse=0, load_err=0, tick_q=0, independent of clk.
REQ-027 SHALL, when clr is released while tick_in=1, count the first edge because tick_q=0; a clr asserted mid-count discards any partial carry.

Structure
REQ-028 SHALL place SEC_MAX=8'h59, MIN_MAX=8'h59, the BCD-pair type and the BCD validity check in shared package time_pkg.
REQ-029 SHALL implement each field as sub-module bcd_mod_counter (parameter MAX_BCD; ports inc, ld, ld_val, q, wrap), instantiated three times and chained through wrap -> inc.
REQ-030 SHALL have no clocks other than clk; tick_in SHALL NOT be used as a clock.

Verification
REQ-031 SHALL cover clr, then one rising edge of tick_in with run=1 -> ss=0x01 one cycle later; tick_in held high 10 cycles -> still 0x01.
REQ-032 SHALL cover load 23:59:59, then one tick -> 00:00:00 with day_pulse=1 for exactly 1 cycle.
REQ-033 SHALL cover load 09:09:59, then one tick -> 09:10:00; repeat from 09:59:59 -> 10:00:00 with no hex digits.
REQ-034 SHALL cover load 0x12:0x6A:0x00 -> time unchanged and load_err=1; then load 12:00:00 -> load_err=0 and time 12:00:00.
REQ-035 SHALL cover a tick edge coincident with load 05:00:00 -> 05:00:00 (tick dropped); a tick with run=0 -> no change.
REQ-036 SHALL cover clr asserted mid-count at 07:30:15 between clk edges -> immediate 00:00:00 and load_err=0.
